// File: rtl/shared_resource_arbiter_if.sv
// Bundle of request, resource, response and return signals for the shared-resource arbiter.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface shared_resource_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_flush;
  logic [NUM_REQ-1:0]            req_stall;

  logic                          res_valid;
  logic [DATA_WIDTH-1:0]         res_data;
  logic                          res_flush;
  logic                          res_stall;

  logic                          rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_flush;
  logic                          rsp_stall;

  logic [NUM_REQ-1:0]            ret_valid;
  logic [DATA_WIDTH-1:0]         ret_data;
  logic                          ret_flush;
  logic [NUM_REQ-1:0]            ret_stall;

  logic                          err_orphan;

  modport slave (
    input  req_valid, req_data, req_flush, res_stall,
    input  rsp_valid, rsp_data, rsp_flush, ret_stall,
    output req_stall, res_valid, res_data, res_flush,
    output rsp_stall, ret_valid, ret_data, ret_flush, err_orphan
  );

  modport master (
    output req_valid, req_data, req_flush, res_stall,
    output rsp_valid, rsp_data, rsp_flush, ret_stall,
    input  req_stall, res_valid, res_data, res_flush,
    input  rsp_stall, ret_valid, ret_data, ret_flush, err_orphan
  );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Round-robin arbiter for one shared resource with a tag queue that routes in-order
// responses back to the issuing requester; stall is the only backpressure.
module shared_resource_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  shared_resource_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(TAG_DEPTH);
  localparam logic [IDW:0]   NUM_EXT  = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_tag_q [TAG_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_flush;
  logic                  r_err_orphan;

  logic [2*NUM_REQ-1:0]  w_rot;
  logic                  w_found;
  logic [IDW:0]          w_sum;
  logic [IDW-1:0]        w_grant;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_flush;
  logic [IDW-1:0]        w_head;
  logic                  w_head_stall;
  logic                  w_route;
  logic                  w_pop;
  logic                  w_orphan;
  logic [NUM_REQ-1:0]    w_ret_valid;
  logic [NUM_REQ-1:0]    w_req_stall;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    w_rot   = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      end
    end
    if (w_sum >= NUM_EXT) begin
      w_sum = w_sum - NUM_EXT;
    end
    w_grant = w_sum[IDW-1:0];
  end

  assign w_accept = reset && !bus.res_stall && !w_full && (|bus.req_valid);

  always_comb begin
    w_sel_data  = '0;
    w_sel_flush = 1'b0;
    w_req_stall = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_flush = bus.req_flush[i];
        w_req_stall[i] = !w_accept;
      end
    end
  end

  assign w_head   = r_tag_q[r_rd_ptr];
  assign w_route  = bus.rsp_valid && !w_empty;
  assign w_orphan = bus.rsp_valid && w_empty;

  // Response path is purely combinational: the queue head selects the owning back-end.
  always_comb begin
    w_head_stall = 1'b0;
    w_ret_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_head == IDW'(i)) begin
        w_head_stall   = bus.ret_stall[i];
        w_ret_valid[i] = w_route;
      end
    end
  end

  assign w_pop = w_route && !w_head_stall;

  assign bus.req_stall  = w_req_stall;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_flush  = r_res_flush;
  assign bus.rsp_stall  = w_route && w_head_stall;
  assign bus.ret_valid  = w_ret_valid;
  assign bus.ret_data   = bus.rsp_data;
  assign bus.ret_flush  = bus.rsp_flush;
  assign bus.err_orphan = r_err_orphan;

  // Issue register and round-robin pointer; everything holds while the resource stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_flush <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (!bus.res_stall) begin
      r_res_valid <= w_accept;
      if (w_accept) begin
        r_res_data  <= w_sel_data;
        r_res_flush <= w_sel_flush;
        r_rr_ptr    <= (w_grant == LAST_ID) ? '0 : w_grant + IDW'(1);
      end
    end
  end

  // Tag queue; accept already excludes the full case, so a pop never frees a slot same-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        r_tag_q[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_tag_q[r_wr_ptr] <= w_grant;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_orphan <= 1'b0;
    end else if (w_orphan) begin
      r_err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based reference model of arbitration and routing.
module tb_shared_resource_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TD = 8;

  logic clk;
  logic reset;

  shared_resource_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  shared_resource_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [DW-1:0] pay [NR];

  // Reference model state
  int            m_q [$];
  int            m_rr;
  logic          m_res_valid;
  logic [DW-1:0] m_res_data;
  logic          m_res_flush;
  logic          m_orphan;

  // Expectations for the current cycle
  logic          e_acc;
  int            e_grant;
  logic          e_pop;
  logic          e_orph;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr        = 0;
    m_res_valid = 1'b0;
    m_res_data  = '0;
    m_res_flush = 1'b0;
    m_orphan    = 1'b0;
  endtask

  task automatic set_req(input logic [NR-1:0] v, input logic [NR-1:0] f);
    bus.req_valid = v;
    bus.req_flush = f;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = pay[i];
  endtask

  task automatic set_rsp(input logic v, input logic [DW-1:0] d, input logic f, input logic [NR-1:0] rs);
    bus.rsp_valid = v;
    bus.rsp_data  = d;
    bus.rsp_flush = f;
    bus.ret_stall = rs;
  endtask

  task automatic eval_comb();
    logic [NR-1:0] e_req_stall;
    logic [NR-1:0] e_ret_valid;
    logic          e_rsp_stall;
    int            idx;
    int            h;
    #1;
    e_acc   = !bus.res_stall && (m_q.size() < TD) && (bus.req_valid != '0);
    e_grant = 0;
    if (e_acc) begin
      for (int k = NR - 1; k >= 0; k--) begin
        idx = (m_rr + k) % NR;
        if (((bus.req_valid >> idx) & 4'd1) != 0) e_grant = idx;
      end
    end
    e_req_stall = e_acc ? ~(4'd1 << e_grant) : 4'hF;
    e_ret_valid = '0;
    e_rsp_stall = 1'b0;
    e_pop       = 1'b0;
    e_orph      = 1'b0;
    if (bus.rsp_valid) begin
      if (m_q.size() > 0) begin
        h           = m_q[0];
        e_ret_valid = 4'd1 << h;
        e_rsp_stall = ((bus.ret_stall >> h) & 4'd1) != 0;
        e_pop       = !e_rsp_stall;
      end else begin
        e_orph = 1'b1;
      end
    end
    chk("req_stall", bus.req_stall, e_req_stall);
    chk("ret_valid", bus.ret_valid, e_ret_valid);
    chk("rsp_stall", bus.rsp_stall, e_rsp_stall);
    chk("ret_data",  bus.ret_data,  bus.rsp_data);
    chk("ret_flush", bus.ret_flush, bus.rsp_flush);
    chk("count",     dut.r_count,   m_q.size());
  endtask

  task automatic clock();
    if (e_pop) void'(m_q.pop_front());
    if (e_acc) m_q.push_back(e_grant);
    if (!bus.res_stall) begin
      m_res_valid = e_acc;
      if (e_acc) begin
        m_res_data  = pay[e_grant];
        m_res_flush = bus.req_flush[e_grant];
        m_rr        = (e_grant + 1) % NR;
      end
    end
    if (e_orph) m_orphan = 1'b1;
    @(posedge clk);
    #1;
    chk("res_valid",  bus.res_valid,  m_res_valid);
    chk("res_data",   bus.res_data,   m_res_data);
    chk("res_flush",  bus.res_flush,  m_res_flush);
    chk("err_orphan", bus.err_orphan, m_orphan);
  endtask

  task automatic step();
    eval_comb();
    clock();
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && m_q.size() > 0; n++) begin
      set_rsp(1'b1, $urandom, 1'($urandom_range(0, 1)), '0);
      step();
    end
    set_rsp(1'b0, '0, 1'b0, '0);
    chk("drained", dut.r_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.res_stall = 1'b0;
    for (int i = 0; i < NR; i++) pay[i] = '0;
    set_req('0, '0);
    set_rsp(1'b0, '0, 1'b0, '0);
    model_reset();

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid",  bus.res_valid,  1'b0);
    chk("rst_req_stall",  bus.req_stall,  4'hF);
    chk("rst_ret_valid",  bus.ret_valid,  4'h0);
    chk("rst_err_orphan", bus.err_orphan, 1'b0);
    reset = 1'b1;
    eval_comb();
    chk("idle_req_stall", bus.req_stall, 4'hF);
    clock();
    chk("idle_res_valid", bus.res_valid, 1'b0);

    // Round robin with every requester active; fills the tag queue
    for (int i = 0; i < NR; i++) pay[i] = 32'h100 + i;
    set_req(4'hF, 4'b0101);
    for (int k = 0; k < TD; k++) begin
      step();
      chk("rr_valid", bus.res_valid, 1'b1);
      chk("rr_data",  bus.res_data,  32'h100 + (k % NR));
    end
    eval_comb();
    chk("full_stall", bus.req_stall, 4'hF);
    clock();
    chk("full_no_issue", bus.res_valid, 1'b0);
    set_rsp(1'b1, 32'hD0, 1'b0, '0);
    eval_comb();
    chk("full_pop_stall", bus.req_stall, 4'hF);
    clock();
    set_rsp(1'b0, '0, 1'b0, '0);
    eval_comb();
    chk("reaccept", bus.req_stall, 4'b1110);
    clock();
    set_req('0, '0);
    drain();

    // Routing to requesters 2, 0, 3 with a back-end stall on the second response
    pay[2] = 32'h22; set_req(4'b0100, '0); step();
    pay[0] = 32'h20; set_req(4'b0001, '0); step();
    pay[3] = 32'h23; set_req(4'b1000, '0); step();
    set_req('0, '0);
    set_rsp(1'b1, 32'hA, 1'b0, '0);
    eval_comb();
    chk("route_a_valid", bus.ret_valid, 4'b0100);
    chk("route_a_data",  bus.ret_data,  32'hA);
    clock();
    set_rsp(1'b1, 32'hB, 1'b1, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      eval_comb();
      chk("route_b_stall", bus.rsp_stall, 1'b1);
      chk("route_b_valid", bus.ret_valid, 4'b0001);
      chk("route_b_data",  bus.ret_data,  32'hB);
      clock();
    end
    set_rsp(1'b1, 32'hB, 1'b1, '0);
    eval_comb();
    chk("route_b_release", bus.rsp_stall, 1'b0);
    clock();
    set_rsp(1'b1, 32'hC, 1'b0, '0);
    eval_comb();
    chk("route_c_valid", bus.ret_valid, 4'b1000);
    chk("route_c_data",  bus.ret_data,  32'hC);
    clock();
    set_rsp(1'b0, '0, 1'b0, '0);

    // Resource stall holds the issue register and the pointer
    pay[3] = 32'h55; set_req(4'b1000, '0); step();
    pay[1] = 32'h1234; set_req(4'b0010, 4'b0010);
    bus.res_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eval_comb();
      chk("rstall_req1", bus.req_stall[1], 1'b1);
      clock();
      chk("rstall_hold_data",  bus.res_data,  32'h55);
      chk("rstall_hold_valid", bus.res_valid, 1'b1);
      chk("rstall_rr",         dut.r_rr_ptr,  0);
    end
    bus.res_stall = 1'b0;
    eval_comb();
    chk("rstall_grant", bus.req_stall, 4'b1101);
    clock();
    chk("rstall_issue_data",  bus.res_data,  32'h1234);
    chk("rstall_issue_flush", bus.res_flush, 1'b1);
    set_req('0, '0);
    drain();

    // Orphan response, then asynchronous reset with tags outstanding
    set_rsp(1'b1, 32'hEE, 1'b0, '0);
    eval_comb();
    chk("orphan_ret_valid", bus.ret_valid, 4'h0);
    chk("orphan_rsp_stall", bus.rsp_stall, 1'b0);
    clock();
    chk("orphan_flag", bus.err_orphan, 1'b1);
    set_rsp(1'b0, '0, 1'b0, '0);
    step();
    chk("orphan_sticky", bus.err_orphan, 1'b1);
    for (int i = 0; i < NR; i++) pay[i] = 32'h300 + i;
    set_req(4'hF, '0);
    repeat (3) step();
    set_rsp(1'b1, 32'h77, 1'b0, '0);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_err_orphan", bus.err_orphan, 1'b0);
    chk("arst_res_valid",  bus.res_valid,  1'b0);
    chk("arst_res_data",   bus.res_data,   '0);
    chk("arst_count",      dut.r_count,    0);
    chk("arst_req_stall",  bus.req_stall,  4'hF);
    chk("arst_ret_valid",  bus.ret_valid,  4'h0);
    chk("arst_rsp_stall",  bus.rsp_stall,  1'b0);
    set_req('0, '0);
    set_rsp(1'b0, '0, 1'b0, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [NR-1:0] rs;
      for (int i = 0; i < NR; i++) pay[i] = $urandom;
      set_req(NR'($urandom_range(0, 15)), NR'($urandom_range(0, 15)));
      bus.res_stall = ($urandom_range(0, 3) == 0);
      rs = '0;
      for (int i = 0; i < NR; i++) rs[i] = ($urandom_range(0, 3) == 0);
      set_rsp((m_q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom,
              1'($urandom_range(0, 1)), rs);
      step();
    end
    set_req('0, '0);
    bus.res_stall = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
